// File: rtl/memcopy_pkg.sv
// memcopy_pkg
// Shared definitions for the memcopy instruction engine: the sequencer state
// encoding, the word size in bytes and the custom opcode that the decoder
// matches to raise the memcopy control bit.
// No ports (package).
package memcopy_pkg;

  typedef enum logic [1:0] {
    MC_IDLE,
    MC_READ,
    MC_WRITE,
    MC_DONE
  } mc_state_t;

  localparam int         WORD_BYTES  = 4;
  localparam logic [6:0] OPC_MEMCOPY = 7'b1111111;

endpackage

// File: rtl/memcopy_sequencer.sv
// memcopy_sequencer
// Multi-cycle engine for the memcopy instruction. Copies len words from
// src_addr to dst_addr through the single-port data memory, alternating one
// read cycle and one write cycle per word, lowest address first. The pipeline
// is stalled from the decode cycle until the last write; done pulses the
// cycle after that, when the pipeline is allowed to advance.
//
// Ports:
//   clk, reset           clock (rising edge), synchronous active-high reset
//   memcopy              decoder control bit, high while memcopy is in decode
//   src_addr, dst_addr   word-aligned byte addresses, latched on start
//   len                  number of words to copy, latched on start
//   mem_rdata            memory read data, valid the cycle after mem_read
//   mem_addr, mem_read,
//   mem_write, mem_wdata data-memory port, owned by this block while stall=1
//   stall                freezes PC and decode
//   done                 one-cycle completion pulse
//   error                one-cycle bounds-violation pulse (with done)
//
// Optional feature: define MEMCOPY_BOUNDS_CHECK_EN to reject copies whose
// source or destination range runs past MEM_BYTES. Without it, error is 0 and
// addresses simply wrap modulo 2**ADDR_W.
module memcopy_sequencer
  import memcopy_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int LEN_W     = 8,
  parameter int MEM_BYTES = 4096
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              memcopy,
  input  logic [ADDR_W-1:0] src_addr,
  input  logic [ADDR_W-1:0] dst_addr,
  input  logic [LEN_W-1:0]  len,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_read,
  output logic              mem_write,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              stall,
  output logic              done,
  output logic              error
);

  localparam int STRIDE = DATA_W / 8;

  mc_state_t         state_q, state_d;
  logic [ADDR_W-1:0] src_q, src_d;
  logic [ADDR_W-1:0] dst_q, dst_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [LEN_W-1:0]  idx_q, idx_d;
  logic [ADDR_W-1:0] word_off;
  logic              start_oob;

  // Byte offset of the current word; wraps modulo the address width.
  assign word_off = ADDR_W'(idx_q) * ADDR_W'(STRIDE);

`ifdef MEMCOPY_BOUNDS_CHECK_EN
  logic              err_q, err_d;
  logic [ADDR_W:0]   span;
  logic [ADDR_W:0]   src_end;
  logic [ADDR_W:0]   dst_end;

  // The end addresses get one extra bit so a range that wraps past the top of
  // the address space is still seen as out of bounds.
  assign span      = (ADDR_W+1)'(len) * (ADDR_W+1)'(STRIDE);
  assign src_end   = {1'b0, src_addr} + span;
  assign dst_end   = {1'b0, dst_addr} + span;
  assign start_oob = (src_end > (ADDR_W+1)'(MEM_BYTES)) ||
                     (dst_end > (ADDR_W+1)'(MEM_BYTES));
  assign error     = (state_q == MC_DONE) && err_q;
`else
  logic unused_mem_bytes;

  // MEM_BYTES only sizes the bounds check, which is absent in this build.
  assign unused_mem_bytes = (MEM_BYTES != 0);
  assign start_oob        = 1'b0;
  assign error            = 1'b0;
`endif

  // State and operand registers; reset puts the engine back in IDLE at once,
  // abandoning any copy in flight without a done pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= MC_IDLE;
      src_q   <= '0;
      dst_q   <= '0;
      len_q   <= '0;
      idx_q   <= '0;
`ifdef MEMCOPY_BOUNDS_CHECK_EN
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      len_q   <= len_d;
      idx_q   <= idx_d;
`ifdef MEMCOPY_BOUNDS_CHECK_EN
      err_q   <= err_d;
`endif
    end
  end

  // Next-state and memory-port control. Stall in IDLE follows memcopy
  // combinationally so the instruction is frozen in its decode cycle. DONE
  // ignores memcopy: the pipeline advances there, and the still-asserted
  // control bit of the finished instruction must not start a second copy.
  always_comb begin
    state_d   = state_q;
    src_d     = src_q;
    dst_d     = dst_q;
    len_d     = len_q;
    idx_d     = idx_q;
    mem_addr  = '0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    mem_wdata = '0;
    stall     = 1'b0;
    done      = 1'b0;
`ifdef MEMCOPY_BOUNDS_CHECK_EN
    err_d     = err_q;
`endif
    unique case (state_q)
      MC_IDLE: begin
        stall = memcopy;
        if (memcopy) begin
          src_d = src_addr;
          dst_d = dst_addr;
          len_d = len;
          idx_d = '0;
`ifdef MEMCOPY_BOUNDS_CHECK_EN
          err_d = start_oob;
`endif
          if ((len == '0) || start_oob) begin
            state_d = MC_DONE;
          end else begin
            state_d = MC_READ;
          end
        end
      end
      MC_READ: begin
        stall    = 1'b1;
        mem_read = 1'b1;
        mem_addr = src_q + word_off;
        state_d  = MC_WRITE;
      end
      MC_WRITE: begin
        stall     = 1'b1;
        mem_write = 1'b1;
        mem_addr  = dst_q + word_off;
        mem_wdata = mem_rdata;
        idx_d     = idx_q + LEN_W'(1);
        if ((idx_q + LEN_W'(1)) == len_q) begin
          state_d = MC_DONE;
        end else begin
          state_d = MC_READ;
        end
      end
      MC_DONE: begin
        done    = 1'b1;
        state_d = MC_IDLE;
`ifdef MEMCOPY_BOUNDS_CHECK_EN
        err_d   = 1'b0;
`endif
      end
      default: begin
        state_d = MC_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_memcopy_sequencer.sv
// tb_memcopy_sequencer
// Directed bench for memcopy_sequencer. A small word-addressed memory model
// answers reads one cycle late and commits writes on the clock edge; a
// backdoor port on the same model preloads and clears words between tests.
// Outputs are sampled 2 time units after the rising edge.
module tb_memcopy_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        memcopy;
  logic [31:0] src_addr;
  logic [31:0] dst_addr;
  logic [7:0]  len;
  logic [31:0] mem_rdata;
  logic [31:0] mem_addr;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_wdata;
  logic        stall;
  logic        done;
  logic        error;

  logic [31:0] mem [0:1023];
  logic        bd_we = 1'b0;
  logic [31:0] bd_addr = '0;
  logic [31:0] bd_data = '0;
  int          rd_count = 0;
  int          wr_count = 0;

  int pass_count = 0;
  int check_count = 0;

  localparam logic [31:0] WORD_A = 32'hAAAA_0001;
  localparam logic [31:0] WORD_B = 32'hBBBB_0002;
  localparam logic [31:0] WORD_C = 32'hCCCC_0003;
  localparam logic [31:0] WORD_D = 32'hDDDD_0004;
  localparam logic [31:0] WORD_X = 32'h1234_5678;
  localparam logic [31:0] WORD_Y = 32'h9ABC_DEF0;

  memcopy_sequencer #(
    .ADDR_W(32), .DATA_W(32), .LEN_W(8), .MEM_BYTES(4096)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .memcopy   (memcopy),
    .src_addr  (src_addr),
    .dst_addr  (dst_addr),
    .len       (len),
    .mem_rdata (mem_rdata),
    .mem_addr  (mem_addr),
    .mem_read  (mem_read),
    .mem_write (mem_write),
    .mem_wdata (mem_wdata),
    .stall     (stall),
    .done      (done),
    .error     (error)
  );

  always #5 clk = ~clk;

  // Data memory model: registered read data, write on the edge, plus a
  // backdoor write port and access counters for the bench.
  always @(posedge clk) begin
    if (mem_read) begin
      mem_rdata <= mem[mem_addr[11:2]];
      rd_count  <= rd_count + 1;
    end
    if (mem_write) begin
      mem[mem_addr[11:2]] <= mem_wdata;
      wr_count            <= wr_count + 1;
    end
    if (bd_we) begin
      mem[bd_addr[11:2]] <= bd_data;
    end
  end

  // Advance to the next cycle and settle just after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic mc, input logic [31:0] src,
                               input logic [31:0] dst, input logic [7:0] n);
    memcopy  = mc;
    src_addr = src;
    dst_addr = dst;
    len      = n;
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    check_count++;
    assert (observed === expected) pass_count++;
    else $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
  endtask

  task automatic preload(input logic [31:0] addr, input logic [31:0] data);
    bd_addr = addr;
    bd_data = data;
    bd_we   = 1'b1;
    tick();
    bd_we   = 1'b0;
  endtask

  // Expected port activity for cycles 1..7 of the len=3 copy.
  logic [31:0] exp_addr  [1:7] = '{32'h100, 32'h200, 32'h104, 32'h204, 32'h108, 32'h208, 32'h0};
  logic [31:0] exp_wdata [1:7] = '{32'h0, WORD_A, 32'h0, WORD_B, 32'h0, WORD_C, 32'h0};
  logic        exp_rd    [1:7] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
  logic        exp_wr    [1:7] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
  logic        exp_stall [1:7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
  logic        exp_done  [1:7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

  initial begin
    int rd0;
    int wr0;
    int done_cycle;

    // Reset state
    reset = 1'b1;
    applyStimulus(1'b0, 32'h0, 32'h0, 8'd0);
    tick();
    tick();
    checkOutput("rst_stall", 32'(stall), 32'd0);
    checkOutput("rst_done", 32'(done), 32'd0);
    checkOutput("rst_error", 32'(error), 32'd0);
    checkOutput("rst_read", 32'(mem_read), 32'd0);
    checkOutput("rst_write", 32'(mem_write), 32'd0);
    checkOutput("rst_addr", mem_addr, 32'h0);
    checkOutput("rst_wdata", mem_wdata, 32'h0);
    reset = 1'b0;

    // len=3 copy 0x100 -> 0x200; memcopy drops after the start cycle and the
    // source operand changes, so the latched operands must carry the copy.
    preload(32'h100, WORD_A);
    preload(32'h104, WORD_B);
    preload(32'h108, WORD_C);
    applyStimulus(1'b1, 32'h100, 32'h200, 8'd3);
    checkOutput("c0_stall", 32'(stall), 32'd1);
    checkOutput("c0_read", 32'(mem_read), 32'd0);
    tick();
    applyStimulus(1'b0, 32'h500, 32'h600, 8'd9);
    for (int c = 1; c <= 7; c++) begin
      if (c > 1) begin
        tick();
        #1;
      end
      checkOutput($sformatf("c%0d_read", c), 32'(mem_read), 32'(exp_rd[c]));
      checkOutput($sformatf("c%0d_write", c), 32'(mem_write), 32'(exp_wr[c]));
      checkOutput($sformatf("c%0d_addr", c), mem_addr, exp_addr[c]);
      checkOutput($sformatf("c%0d_wdata", c), mem_wdata, exp_wdata[c]);
      checkOutput($sformatf("c%0d_stall", c), 32'(stall), 32'(exp_stall[c]));
      checkOutput($sformatf("c%0d_done", c), 32'(done), 32'(exp_done[c]));
    end
    checkOutput("c7_error", 32'(error), 32'd0);
    tick();
    checkOutput("c8_done", 32'(done), 32'd0);
    checkOutput("copy_mem200", mem[32'h200 >> 2], WORD_A);
    checkOutput("copy_mem204", mem[32'h204 >> 2], WORD_B);
    checkOutput("copy_mem208", mem[32'h208 >> 2], WORD_C);

    // len=0: one stall cycle, done on cycle 1, no memory access
    rd0 = rd_count;
    wr0 = wr_count;
    applyStimulus(1'b1, 32'h100, 32'h200, 8'd0);
    checkOutput("len0_c0_stall", 32'(stall), 32'd1);
    tick();
    applyStimulus(1'b0, 32'h0, 32'h0, 8'd0);
    checkOutput("len0_c1_done", 32'(done), 32'd1);
    checkOutput("len0_c1_stall", 32'(stall), 32'd0);
    checkOutput("len0_c1_error", 32'(error), 32'd0);
    tick();
    checkOutput("len0_c2_done", 32'(done), 32'd0);
    checkOutput("len0_reads", 32'(rd_count - rd0), 32'd0);
    checkOutput("len0_writes", 32'(wr_count - wr0), 32'd0);

    // memcopy held high through the DONE cycle: DONE must not restart
    preload(32'h300, WORD_D);
    rd0 = rd_count;
    wr0 = wr_count;
    applyStimulus(1'b1, 32'h300, 32'h380, 8'd1);
    tick();
    tick();
    checkOutput("hold_c2_write", 32'(mem_write), 32'd1);
    tick();
    checkOutput("hold_c3_done", 32'(done), 32'd1);
    checkOutput("hold_c3_stall", 32'(stall), 32'd0);
    checkOutput("hold_c3_read", 32'(mem_read), 32'd0);
    tick();
    applyStimulus(1'b0, 32'h0, 32'h0, 8'd0);
    checkOutput("hold_c4_done", 32'(done), 32'd0);
    tick();
    checkOutput("hold_c5_read", 32'(mem_read), 32'd0);
    checkOutput("hold_c5_done", 32'(done), 32'd0);
    checkOutput("hold_reads", 32'(rd_count - rd0), 32'd1);
    checkOutput("hold_writes", 32'(wr_count - wr0), 32'd1);
    checkOutput("hold_mem380", mem[32'h380 >> 2], WORD_D);

    // Reset on cycle 3 of a len=4 copy: only 0x200 gets written
    preload(32'h200, 32'h0);
    preload(32'h204, 32'h0);
    preload(32'h208, 32'h0);
    applyStimulus(1'b1, 32'h100, 32'h200, 8'd4);
    tick();
    applyStimulus(1'b0, 32'h0, 32'h0, 8'd0);
    tick();
    tick();
    checkOutput("rstmid_c3_read", 32'(mem_read), 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    checkOutput("rstmid_c4_read", 32'(mem_read), 32'd0);
    checkOutput("rstmid_c4_write", 32'(mem_write), 32'd0);
    checkOutput("rstmid_c4_stall", 32'(stall), 32'd0);
    checkOutput("rstmid_c4_done", 32'(done), 32'd0);
    tick();
    checkOutput("rstmid_c5_write", 32'(mem_write), 32'd0);
    checkOutput("rstmid_c5_done", 32'(done), 32'd0);
    tick();
    checkOutput("rstmid_c6_done", 32'(done), 32'd0);
    checkOutput("rstmid_mem200", mem[32'h200 >> 2], WORD_A);
    checkOutput("rstmid_mem204", mem[32'h204 >> 2], 32'h0);

    // Overlapping forward copy 0x100 -> 0x104, len=2
    preload(32'h100, WORD_X);
    preload(32'h104, WORD_Y);
    applyStimulus(1'b1, 32'h100, 32'h104, 8'd2);
    tick();
    applyStimulus(1'b0, 32'h0, 32'h0, 8'd0);
    done_cycle = 0;
    for (int i = 1; i <= 20; i++) begin
      if (done) begin
        done_cycle = i;
        break;
      end
      tick();
    end
    checkOutput("ovl_done_cycle", 32'(done_cycle), 32'd5);
    tick();
    checkOutput("ovl_mem104", mem[32'h104 >> 2], WORD_X);
    checkOutput("ovl_mem108", mem[32'h108 >> 2], WORD_X);

`ifdef MEMCOPY_BOUNDS_CHECK_EN
    // Destination range 0xFFC..0x1003 exceeds 4096 bytes
    rd0 = rd_count;
    wr0 = wr_count;
    applyStimulus(1'b1, 32'h100, 32'hFFC, 8'd2);
    checkOutput("oob_c0_read", 32'(mem_read), 32'd0);
    tick();
    applyStimulus(1'b0, 32'h0, 32'h0, 8'd0);
    checkOutput("oob_c1_done", 32'(done), 32'd1);
    checkOutput("oob_c1_error", 32'(error), 32'd1);
    tick();
    checkOutput("oob_c2_error", 32'(error), 32'd0);
    checkOutput("oob_reads", 32'(rd_count - rd0), 32'd0);
    checkOutput("oob_writes", 32'(wr_count - wr0), 32'd0);
`endif

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule

// File: doc/memcopy_sequencer.md
Name: memcopy_sequencer

Overview:
- Multi-cycle execution engine for the custom memcopy instruction (opcode 7'b1111111).
- Started by the decoder's memcopy control bit. Copies LEN 32-bit words from a source byte address to a destination byte address through the single-port data memory.
- Holds the pipeline stalled until the copy completes.
- Sits beside the load/store path and owns the data-memory port while busy.

Parameters:
- ADDR_W, 32: byte address width.
- DATA_W, 32: word width; the word stride is DATA_W/8 bytes.
- LEN_W, 8: width of the word-count operand.
- MEM_BYTES, 4096: data memory size in bytes; used only by the optional feature.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- memcopy  in  1  decoder control bit; held high while the memcopy instruction is in decode.
- src_addr  in  ADDR_W  source byte address (rs1 value); word-aligned.
- dst_addr  in  ADDR_W  destination byte address (rs2 value); word-aligned.
- len  in  LEN_W  number of words to copy.
- mem_rdata  in  DATA_W  memory read data, valid one cycle after mem_read.
- mem_addr  out  ADDR_W  memory byte address.
- mem_read  out  1  read strobe.
- mem_write  out  1  write strobe.
- mem_wdata  out  DATA_W  write data.
- stall  out  1  freezes PC and decode.
- done  out  1  one-cycle completion pulse.
- error  out  1  one-cycle bounds-violation pulse; tied to 0 without the optional feature.

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high.
- Reset values: state IDLE, all registers 0, mem_read=0, mem_write=0, mem_addr=0, mem_wdata=0, stall=0, done=0, error=0.
- States: IDLE, READ, WRITE, DONE.
- IDLE:
  - stall = memcopy (combinational), so the instruction is frozen in the same cycle it is decoded.
  - On memcopy=1, latch src_addr, dst_addr and len, and clear the index.
  - Next state is DONE if len==0, otherwise READ.
- READ: mem_read=1, mem_addr = src_reg + idx*4, stall=1. Next state is WRITE.
- WRITE:
  - mem_write=1, mem_addr = dst_reg + idx*4, mem_wdata = mem_rdata (pass-through of the previous cycle's read), stall=1.
  - idx increments.
  - If idx+1 == len_reg, next state is DONE; otherwise READ.
- DONE: done=1, stall=0, memcopy is ignored. Next state is IDLE, because the pipeline advances this cycle and memcopy from the old instruction must not retrigger.
- Timing: with the start cycle as cycle 0, stall is high on cycles 0..2N and done pulses on cycle 2N+1. Throughput is 2 cycles per word.
- Address arithmetic: ADDR_W-bit modulo; wrap-around past the top of the address space is not flagged without the optional feature.
- Length: len is unsigned, so 255 copies 255 words. idx is LEN_W bits wide.
- Overlap: forward copy, lowest address first. When dst is in (src, src+4*len), source words are overwritten before they are read; this is defined behaviour, not an error.
- Read and write strobes are never high in the same cycle.
- Reset mid-copy: returns to IDLE at the next edge. Strobes drop that cycle; no done pulse.
- When memcopy falls while the engine is busy, the copy continues; the latched operands are used.

Optional Feature:
- MEMCOPY_BOUNDS_CHECK_EN defined:
  - In IDLE on start, if src_addr+4*len > MEM_BYTES or dst_addr+4*len > MEM_BYTES (computed at ADDR_W+1 bits), go to DONE without any memory access.
  - error pulses together with done.
- MEMCOPY_BOUNDS_CHECK_EN undefined: no check; error is constant 0.

Decomposition:
- Shared package memcopy_pkg holds:
  - typedef enum logic [1:0] mc_state_t {MC_IDLE, MC_READ, MC_WRITE, MC_DONE};
  - localparam WORD_BYTES = 4;
  - localparam OPC_MEMCOPY = 7'b1111111.
- A single module; no sub-module is warranted.
- The top level muxes mem_* between this block and the load/store path, selected by stall.

Test Plan:
- len=3, src=0x100, dst=0x200, mem[0x100..0x108]=A,B,C:
  - reads at 0x100, 0x104, 0x108 on cycles 1, 3, 5; writes at 0x200, 0x204, 0x208 on cycles 2, 4, 6;
  - done on cycle 7; stall high on cycles 0–6; mem[0x200..0x208]=A,B,C.
- len=0: stall for one cycle, done on cycle 1, no mem_read or mem_write.
- memcopy held high through the DONE cycle and one cycle beyond: exactly one copy and one done pulse; no restart.
- reset asserted on cycle 3 of a len=4 copy: state returns to IDLE on cycle 4, strobes low, no done pulse; only 0x200 was written.
- Overlapping copy, src=0x100, dst=0x104, len=2, mem[0x100]=X, mem[0x104]=Y: after completion mem[0x104]=X and mem[0x108]=X.
- MEMCOPY_BOUNDS_CHECK_EN defined, MEM_BYTES=4096, dst=0xFFC, len=2: done and error both pulse on cycle 1, zero memory accesses.
